seq_sub_32: RTL
===============

// Module: seq_sub_32
// PURPOSE
//  Multi-cycle 32-bit subtractor, Z = a - b, computed DIGIT_W bits per clock as a + ~b + 1.
//  Sequential counterpart to the 32-bit ripple adder: it trades latency for a short carry chain.
//  Uses a start/busy/done handshake and serves the datapath FSM for decrement and compare ops.
//  Also flags unsigned borrow (a < b) and a zero result.
// PARAMETERS
//  DIGIT_W  4  bits processed per cycle; legal values 1,2,4,8,16,32; N = 32/DIGIT_W cycles.
// PORTS
//  clk         in   1   single clock; all state updates on the rising edge.
//  rst         in   1   synchronous, active-high reset.
//  start       in   1   request; sampled on clk only when busy==0.
//  a           in   32  minuend; captured on an accepted start.
//  b           in   32  subtrahend; captured on an accepted start.
//  busy        out  1   high while digits are being computed.
//  done        out  1   one-cycle pulse: Z, borrow_out and zero are newly valid.
//  Z           out  32  result a - b, modulo 2^32.
//  borrow_out  out  1   1 when a < b (unsigned), i.e. the final carry is 0.
//  zero        out  1   1 when Z == 0.
// BEHAVIOUR
//  Reset, on any edge with rst=1: state=IDLE, busy=0, done=0, Z=0, borrow_out=0, zero=1.
//    rst overrides start.
//  States:
//    IDLE: busy=0. start=1 -> latch a, ~b, carry=1, digit count=0; go to RUN.
//    RUN: busy=1. Each edge adds DIGIT_W bits of a and ~b plus carry, starting from the LSBs.
//      Shift the sum digit into the internal result and the operands right by DIGIT_W.
//      Update carry; count += 1.
//      On the Nth edge: write the full result to Z.
//      Same edge: borrow_out = ~carry_out, zero = (result==0), done=1; go to DONE.
//    DONE: busy=0, done=1 for exactly this cycle.
//      start=1 -> accepted exactly as in IDLE (back-to-back); go to RUN. Otherwise go to IDLE.
//  Latency: a start accepted at edge k makes done=1 in the cycle after edge k+N.
//    N=8 at the default; throughput is one op per N+1 cycles at best.
//  start while busy=1 is ignored. It is not queued, and the a/b inputs are don't-care.
//  Z, borrow_out and zero hold their last values until the next completion.
//    They never show partial results.
//  Internal operand copies mean a and b may change freely after the accepting edge.
//  Reset mid-RUN aborts the op: no done pulse, and outputs take their reset values.
//  Arithmetic is unsigned modulo 2^32. Wrap example: 0 - 1 = 0xFFFFFFFF with borrow_out=1.
//  The digit counter is $clog2(N)+1 bits wide and must not wrap during RUN.
//    For DIGIT_W=32, RUN lasts exactly one edge.
// CONFIGURATION
//  SEQ_SUB_OVF_EN defined: adds output port ovf (1 bit).
//    ovf = signed two's-complement overflow of a - b: (a[31] != b[31]) && (Z[31] != a[31]).
//    ovf is registered with Z on the completion edge and is 0 on reset.
//  SEQ_SUB_OVF_EN undefined: there is no ovf port and no sign-tracking logic; behaviour is otherwise identical.
// TESTING
//  1. rst=1 for 2 cycles, then idle -> busy=0, done=0, Z=0, borrow_out=0, zero=1. With ovf enabled, ovf=0.
//  2. start, a=0x00000064, b=0x00000019 -> done exactly 9 cycles after the start edge (DIGIT_W=4).
//     Z=0x0000004B, borrow_out=0, zero=0.
//  3. a=0x00000000, b=0x00000001 -> Z=0xFFFFFFFF, borrow_out=1, zero=0. With ovf enabled, ovf=0.
//  4. a=0x80000000, b=0x00000001 -> Z=0x7FFFFFFF, borrow_out=0. With ovf enabled, ovf=1.
//  5. a=b=0xDEADBEEF; hold start=1 with new a/b on every cycle while busy.
//     -> Z=0, zero=1, exactly one done; a second op starts from the DONE cycle.
//  6. Assert rst for 1 cycle at RUN count 3 -> no done pulse, outputs return to reset values.
//     The next start completes correctly.

Source files
------------

// File: rtl/seq_sub_32.sv
// -----------------------------------------------------------------------------
// seq_sub_32 : multi-cycle 32-bit subtractor, Z = a - b.
//
// The difference is formed as a + ~b + 1, DIGIT_W bits per clock, starting at
// the least significant digit.  A start/busy/done handshake frames each
// operation.  The unsigned borrow (a < b) and a zero-result flag are produced
// together with Z.  Result outputs change only on the completion edge, so a
// consumer never sees a partially built difference.
//
// Optional feature macro: SEQ_SUB_OVF_EN
//   When defined, an extra output port `ovf` reports signed two's-complement
//   overflow of a - b.  It is registered alongside Z.  When undefined, the port
//   and all sign-tracking state are absent.
// -----------------------------------------------------------------------------
module seq_sub_32 #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] Z,
    output logic        borrow_out,
    output logic        zero
`ifdef SEQ_SUB_OVF_EN
    ,
    output logic        ovf
`endif
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int N     = 32 / DIGIT_W;     // digits (and RUN edges) per op
    localparam int CNT_W = $clog2(N) + 1;    // wide enough to hold N itself

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject digit widths that do not tile the 32-bit word evenly.
    generate
        if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 ||
              DIGIT_W == 8 || DIGIT_W == 16 || DIGIT_W == 32)) begin : g_bad_digit_w
            $error("seq_sub_32: DIGIT_W must be one of 1,2,4,8,16,32");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // One digit of the ripple: x + y + cin, returning {carry_out, sum_digit}.
    function automatic logic [DIGIT_W:0] digit_add(
        input logic [DIGIT_W-1:0] x,
        input logic [DIGIT_W-1:0] y,
        input logic               cin
    );
        logic [DIGIT_W:0] ext_x;
        logic [DIGIT_W:0] ext_y;
        logic [DIGIT_W:0] ext_c;
        ext_x = {1'b0, x};
        ext_y = {1'b0, y};
        ext_c = {{DIGIT_W{1'b0}}, cin};
        return ext_x + ext_y + ext_c;
    endfunction

    // Place a fresh digit at the top of the result word after shifting the
    // older digits down; after N steps the LSB digit sits at bit 0.
    function automatic logic [31:0] shift_in_digit(
        input logic [31:0]        acc,
        input logic [DIGIT_W-1:0] dig
    );
        logic [31:0] dig_ext;
        dig_ext = 32'(dig);
        return (acc >> DIGIT_W) | (dig_ext << (32 - DIGIT_W));
    endfunction

`ifdef SEQ_SUB_OVF_EN
    // Signed overflow of a - b: operands of different sign and the result's
    // sign differs from the minuend's.
    function automatic logic sub_overflow(
        input logic sign_a,
        input logic sign_b,
        input logic sign_z
    );
        return (sign_a != sign_b) && (sign_z != sign_a);
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Registers and next-state values
    // -------------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [31:0]        a_q,      a_d;       // remaining minuend digits
    logic [31:0]        nb_q,     nb_d;      // remaining inverted subtrahend digits
    logic               carry_q,  carry_d;   // ripple carry between digits
    logic [CNT_W-1:0]   cnt_q,    cnt_d;     // digits already processed
    logic [31:0]        res_q,    res_d;     // partially assembled difference
    logic [31:0]        z_q,      z_d;
    logic               borrow_q, borrow_d;
    logic               zero_q,   zero_d;
    logic               done_q,   done_d;
`ifdef SEQ_SUB_OVF_EN
    logic               sign_a_q, sign_a_d;  // a[31] captured at start
    logic               sign_b_q, sign_b_d;  // b[31] captured at start
    logic               ovf_q,    ovf_d;
`endif

    logic [DIGIT_W:0]   sum_s;               // {carry_out, digit} of current step
    logic [31:0]        res_next_s;          // result word after current step

    assign sum_s      = digit_add(a_q[DIGIT_W-1:0], nb_q[DIGIT_W-1:0], carry_q);
    assign res_next_s = shift_in_digit(res_q, sum_s[DIGIT_W-1:0]);

    // State register and datapath registers; synchronous reset wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= 32'd0;
            nb_q     <= 32'd0;
            carry_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            res_q    <= 32'd0;
            z_q      <= 32'd0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            z_q      <= z_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
`ifdef SEQ_SUB_OVF_EN
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state logic: handshake sequencing plus one digit step per RUN edge.
    always_comb begin
        // Hold everything unless a state below says otherwise; done is a pulse.
        state_d  = state_q;
        a_d      = a_q;
        nb_d     = nb_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        z_d      = z_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
`ifdef SEQ_SUB_OVF_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start exactly like IDLE, giving
                // back-to-back operation with one idle-free turnaround cycle.
                if (start) begin
                    a_d      = a;
                    nb_d     = ~b;
                    carry_d  = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
                    res_d    = 32'd0;
                    state_d  = S_RUN;
`ifdef SEQ_SUB_OVF_EN
                    sign_a_d = a[31];
                    sign_b_d = b[31];
`endif
                end else begin
                    state_d  = S_IDLE;
                end
            end

            S_RUN: begin
                // start is ignored here; the captured operands drive the op.
                a_d     = a_q  >> DIGIT_W;
                nb_d    = nb_q >> DIGIT_W;
                carry_d = sum_s[DIGIT_W];
                res_d   = res_next_s;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Final digit: publish the complete result and flags.
                    z_d      = res_next_s;
                    borrow_d = ~sum_s[DIGIT_W];
                    zero_d   = (res_next_s == 32'd0);
                    done_d   = 1'b1;
                    state_d  = S_DONE;
`ifdef SEQ_SUB_OVF_EN
                    ovf_d    = sub_overflow(sign_a_q, sign_b_q, res_next_s[31]);
`endif
                end else begin
                    state_d  = S_RUN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, all taken directly from registers
    // -------------------------------------------------------------------------
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign Z          = z_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;
`ifdef SEQ_SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule
